// File: rtl/addsub_pkg.sv
// Shared types and helpers for the nibble-serial add/sub unit.
// Provides slice width, FSM state type and saturation constants.
package addsub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed extreme for a w-bit word: 0x80..0 when neg, else 0x7F..F.
    function automatic logic [63:0] sat_value(input int unsigned w,
                                              input logic neg);
        logic [63:0] msb;
        msb = 64'd1 << (w - 1);
        return neg ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit add/sub slice built from four full-adder cells.
// Exposes carries out of bits 3 and 2 for carry chaining and overflow.
module nibble_addsub_slice
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             op,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             c3,
    output logic             c2
);

    logic [NIB_W-1:0] y_eff;
    logic [NIB_W:0]   c;

    assign y_eff = y ^ {NIB_W{op}};
    assign c[0]  = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y_eff[i] ^ c[i];
        assign c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end

    assign c3 = c[NIB_W];
    assign c2 = c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle W-bit add/sub using one 4-bit slice, one nibble per clock.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*NIBBLES-1:0]     a,
    input  logic [4*NIBBLES-1:0]     b,
    input  logic                     op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*NIBBLES-1:0]     result,
    output logic                     carry_out,
    output logic                     overflow
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             op_q;
    logic [W-1:0]     result_q;
    logic             carry_out_q;
    logic             overflow_q;

    logic             accept;
    logic             last;
    logic [CNT_W+1:0] idx;
    logic [NIB_W-1:0] sum;
    logic             c3;
    logic             c2;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    assign last = (cnt_q == LAST);
    assign idx  = {cnt_q, 2'b00};

    nibble_addsub_slice u_slice (
        .x   (a_q[idx +: NIB_W]),
        .y   (b_q[idx +: NIB_W]),
        .op  (op_q),
        .cin (carry_q),
        .s   (sum),
        .c3  (c3),
        .c2  (c2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ADDSUB_SAT_EN
    localparam logic [W-1:0] SAT_POS = W'(sat_value(W, 1'b0));
    localparam logic [W-1:0] SAT_NEG = W'(sat_value(W, 1'b1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= op;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    result_q[idx +: NIB_W] <= sum;
                    carry_q <= c3;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        carry_out_q <= c3;
                        overflow_q  <= c3 ^ c2;
`ifdef ADDSUB_SAT_EN
                        // Sign of the true result equals the sign of a.
                        if (c3 ^ c2) begin
                            result_q <= a_q[W-1] ? SAT_NEG : SAT_POS;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
